// File: rtl/button_event_pkg.sv
// Shared types and defaults for the button event arbiter.
// Event records carry up to 16 channels (4-bit index) plus edge polarity.
package button_event_pkg;

    localparam int WAITTIME_DEF     = 3;
    localparam int COUNTERWIDTH_DEF = 3;
    localparam int MAX_CHAN_W       = 4;

    typedef struct packed {
        logic [MAX_CHAN_W-1:0] chan;
        logic                  rising;
    } evt_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_debouncer.sv
// One-channel synchronizer + debouncer. A level must sit stable at sync1 for
// WAITTIME+1 cycles before it is accepted; rise/fall pulse in the update cycle.
module chan_debouncer
    import button_event_pkg::*;
#(
    parameter int WAITTIME     = WAITTIME_DEF,
    parameter int COUNTERWIDTH = COUNTERWIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    output logic level,
    output logic rise,
    output logic fall
);

    logic                    sync0, sync1;
    logic [COUNTERWIDTH-1:0] cnt;
    logic                    flip;

    // Pulses are combinational so the arbiter slot loads on the same edge as level.
    assign flip = (sync1 != level) && (cnt == COUNTERWIDTH'(WAITTIME));
    assign rise = flip & sync1;
    assign fall = flip & ~sync1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync0 <= noisy;
            sync1 <= sync0;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces NUM_INPUTS buttons and serializes their edges through a
// round-robin valid/ready event port. Define BUTTON_EVENT_OVERFLOW_EN for overflow flags.
module button_event_arbiter
    import button_event_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int WAITTIME     = WAITTIME_DEF,
    parameter int COUNTERWIDTH = COUNTERWIDTH_DEF,
    localparam int CHAN_W      = chan_w(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] noisy,
    output logic [NUM_INPUTS-1:0] conditioned,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [CHAN_W-1:0]     evt_chan,
    output logic                  evt_rising
`ifdef BUTTON_EVENT_OVERFLOW_EN
    ,
    output logic [NUM_INPUTS-1:0] overflow,
    input  logic                  overflow_clr
`endif
);

    logic [NUM_INPUTS-1:0] rise, fall, edge_in;
    logic [NUM_INPUTS-1:0] slot_full, slot_rise, clr_win;
    logic [CHAN_W-1:0]     last, win;
    logic                  found, load, pop;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_deb
        chan_debouncer #(
            .WAITTIME    (WAITTIME),
            .COUNTERWIDTH(COUNTERWIDTH)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .noisy(noisy[g]),
            .level(conditioned[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

    assign edge_in = rise | fall;
    assign load    = ~evt_valid | evt_ready;
    assign pop     = load & found;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        logic [CHAN_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = CHAN_W'((int'(last) + 1 + k) % NUM_INPUTS);
            if (!found && slot_full[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        clr_win = '0;
        if (pop) clr_win[win] = 1'b1;
    end

    // A new edge always wins over a pop of the same slot; newest polarity kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= '0;
            slot_rise <= '0;
        end else begin
            slot_full <= (slot_full & ~clr_win) | edge_in;
            slot_rise <= (slot_rise & ~edge_in) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid  <= 1'b0;
            evt_chan   <= '0;
            evt_rising <= 1'b0;
            last       <= CHAN_W'(NUM_INPUTS - 1);
        end else if (load) begin
            evt_valid <= found;
            if (found) begin
                evt_chan   <= win;
                evt_rising <= slot_rise[win];
                last       <= win;
            end
        end
    end

`ifdef BUTTON_EVENT_OVERFLOW_EN
    logic [NUM_INPUTS-1:0] ovf_set;
    assign ovf_set = edge_in & slot_full & ~clr_win;

    // Set takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= '0;
        else        overflow <= (overflow & ~{NUM_INPUTS{overflow_clr}}) | ovf_set;
    end
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: vector table plus corner-case sequences.
module tb_button_event_arbiter;
    import button_event_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] noisy = '0;
    logic [3:0] conditioned;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_chan;
    logic       evt_rising;
`ifdef BUTTON_EVENT_OVERFLOW_EN
    logic [3:0] overflow;
    logic       overflow_clr = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_event_arbiter #(.NUM_INPUTS(4), .WAITTIME(3), .COUNTERWIDTH(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .noisy       (noisy),
        .conditioned (conditioned),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chan    (evt_chan),
        .evt_rising  (evt_rising)
`ifdef BUTTON_EVENT_OVERFLOW_EN
        ,
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
`endif
    );

    typedef struct {
        bit         rst;
        logic [3:0] noisy;
        bit         rdy;
        bit         ev;
        evt_t       exp_evt;
        logic [3:0] cond;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input bit rst, input logic [3:0] n, input bit rdy,
                       input bit ev, input int ch, input bit r, input logic [3:0] c);
        vec_t v;
        v.rst = rst; v.noisy = n; v.rdy = rdy; v.ev = ev;
        v.exp_evt.chan = 4'(ch); v.exp_evt.rising = r; v.cond = c;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [3:0] n);
        rst_n = 1'b0;
        noisy = n;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_evt(input string nm, input bit v, input int ch, input bit r);
        chk({nm, ".valid"}, 32'(evt_valid), 32'(v));
        if (v) begin
            chk({nm, ".chan"}, 32'(evt_chan), 32'(ch));
            chk({nm, ".rising"}, 32'(evt_rising), 32'(r));
        end
    endtask

    // Rise of ch0 is held (ready=0); ch2 then rises and falls into its pending slot.
    task automatic gen_ovf(input string nm);
        do_reset(4'b0000);
        evt_ready = 1'b0;
        noisy = 4'b0001;
        tick(7);
        chk_evt({nm, ".first"}, 1, 0, 1);
        noisy = 4'b0101;
        tick(8);
        chk({nm, ".cond_hi"}, 32'(conditioned), 32'h5);
        chk_evt({nm, ".held1"}, 1, 0, 1);
        noisy = 4'b0001;
        tick(8);
        chk({nm, ".cond_lo"}, 32'(conditioned), 32'h1);
        chk_evt({nm, ".held2"}, 1, 0, 1);
`ifdef BUTTON_EVENT_OVERFLOW_EN
        chk({nm, ".ovf"}, 32'(overflow), 32'h4);
`endif
        evt_ready = 1'b1;
        tick(1);
        chk_evt({nm, ".newest"}, 1, 2, 0);
        evt_ready = 1'b0;
        tick(1);
        chk_evt({nm, ".newest_held"}, 1, 2, 0);
    endtask

    initial begin
        // S1: ch1 held high, event one cycle after conditioned.
        row(1, 4'h2, 1, 0, 0, 0, 4'h0);
        repeat (4) row(0, 4'h2, 1, 0, 0, 0, 4'h0);
        row(0, 4'h2, 1, 0, 0, 0, 4'h2);
        row(0, 4'h2, 1, 1, 1, 1, 4'h2);
        row(0, 4'h2, 1, 0, 0, 0, 4'h2);
        // S2: 2-cycle glitch on ch0.
        row(1, 4'h1, 1, 0, 0, 0, 4'h0);
        row(0, 4'h1, 1, 0, 0, 0, 4'h0);
        repeat (6) row(0, 4'h0, 1, 0, 0, 0, 4'h0);
        // S3: 3-cycle glitch, the longest that must be rejected.
        row(1, 4'h1, 1, 0, 0, 0, 4'h0);
        repeat (2) row(0, 4'h1, 1, 0, 0, 0, 4'h0);
        repeat (5) row(0, 4'h0, 1, 0, 0, 0, 4'h0);
        // S4: 4-cycle pulse, the shortest that is accepted (rise then fall).
        row(1, 4'h1, 1, 0, 0, 0, 4'h0);
        repeat (3) row(0, 4'h1, 1, 0, 0, 0, 4'h0);
        row(0, 4'h0, 1, 0, 0, 0, 4'h0);
        row(0, 4'h0, 1, 0, 0, 0, 4'h1);
        row(0, 4'h0, 1, 1, 0, 1, 4'h1);
        repeat (2) row(0, 4'h0, 1, 0, 0, 0, 4'h1);
        row(0, 4'h0, 1, 0, 0, 0, 4'h0);
        row(0, 4'h0, 1, 1, 0, 0, 4'h0);
        row(0, 4'h0, 1, 0, 0, 0, 4'h0);
        // S5: all four rise together, then all fall: order 0..3 both times.
        row(1, 4'hF, 1, 0, 0, 0, 4'h0);
        repeat (4) row(0, 4'hF, 1, 0, 0, 0, 4'h0);
        row(0, 4'hF, 1, 0, 0, 0, 4'hF);
        for (int c = 0; c < 4; c++) row(0, 4'hF, 1, 1, c, 1, 4'hF);
        row(0, 4'hF, 1, 0, 0, 0, 4'hF);
        repeat (5) row(0, 4'h0, 1, 0, 0, 0, 4'hF);
        row(0, 4'h0, 1, 0, 0, 0, 4'h0);
        for (int c = 0; c < 4; c++) row(0, 4'h0, 1, 1, c, 0, 4'h0);
        row(0, 4'h0, 1, 0, 0, 0, 4'h0);

        // Reset state.
        #1;
        chk("reset.valid", 32'(evt_valid), 32'h0);
        chk("reset.cond", 32'(conditioned), 32'h0);
        chk("reset.chan", 32'(evt_chan), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (tbl[i].rst) do_reset(4'b0000);
            noisy = tbl[i].noisy;
            evt_ready = tbl[i].rdy;
            tick(1);
            chk({nm, ".cond"}, 32'(conditioned), 32'(tbl[i].cond));
            chk_evt(nm, tbl[i].ev, int'(tbl[i].exp_evt.chan), tbl[i].exp_evt.rising);
        end

        // Overflow with backpressure, then async reset while an event is presented.
        gen_ovf("ovf");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.valid", 32'(evt_valid), 32'h0);
        chk("rst_mid.cond", 32'(conditioned), 32'h0);
`ifdef BUTTON_EVENT_OVERFLOW_EN
        chk("rst_mid.ovf", 32'(overflow), 32'h0);
`endif
        do_reset(4'b0000);
        evt_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick(1);
                if (evt_valid) seen++;
            end
            chk("rst_mid.no_evt", 32'(seen), 32'h0);
        end

`ifdef BUTTON_EVENT_OVERFLOW_EN
        // Sticky until cleared.
        gen_ovf("ovf2");
        tick(3);
        chk("ovf2.sticky", 32'(overflow), 32'h4);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("ovf2.clr", 32'(overflow), 32'h0);
`endif

        // Input high through reset release: event after 2+3+1+1 edges.
        do_reset(4'b0100);
        evt_ready = 1'b1;
        tick(6);
        chk("hold_rst.cond", 32'(conditioned), 32'h4);
        chk_evt("hold_rst.early", 0, 0, 0);
        tick(1);
        chk_evt("hold_rst.evt", 1, 2, 1);
        tick(1);
        chk_evt("hold_rst.after", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001: Parameter NUM_INPUTS, default 4, SHALL be the number of noisy input channels (2..16).
REQ-002: Parameter WAITTIME, default 3, SHALL be the debounce delay in clk cycles (>=1).
REQ-003: Parameter COUNTERWIDTH, default 3, SHALL be the debounce counter width, >= log2(WAITTIME+1).
REQ-004: The module SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006: rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-007: noisy  input  NUM_INPUTS  SHALL be the raw asynchronous button/switch inputs.
REQ-008: conditioned  output  NUM_INPUTS  SHALL be the debounced, synchronized level per channel.
REQ-009: evt_valid  output  1  SHALL indicate an edge event is presented.
REQ-010: evt_ready  input  1  SHALL be consumer acceptance; an event transfers when evt_valid and evt_ready are both 1.
REQ-011: evt_chan  output  CHAN_W (clog2 NUM_INPUTS)  SHALL be the channel index of the presented event.
REQ-012: evt_rising  output  1  SHALL be 1 for rising, 0 for falling edge.
REQ-013: overflow  output  NUM_INPUTS  SHALL be sticky per-channel lost-event flags (present only per REQ-034).
REQ-014: overflow_clr  input  1  SHALL clear all overflow flags (present only per REQ-034).

Function
REQ-015: Each channel SHALL pass noisy through a two-flop synchronizer (sync0, sync1).
REQ-016: Debounce counter SHALL reset to 0 on any cycle where sync1 == conditioned.
REQ-017: When sync1 != conditioned, the counter SHALL increment; on the cycle it equals WAITTIME, conditioned SHALL take sync1 and the counter SHALL return to 0.
REQ-018: A noisy level change held stable SHALL reach conditioned exactly 2+WAITTIME+1 cycles after the first sampling edge; a glitch shorter than WAITTIME+1 cycles at sync1 SHALL never change conditioned.
REQ-019: Each conditioned change SHALL load that channel's one-entry pending slot {full=1, rising=new level} on the same clock edge.
REQ-020: Edge into a full slot not being popped SHALL overwrite the slot's polarity (newest edge wins) and SHALL flag an overflow for that channel.
REQ-021: Edge into a slot popped in the same cycle SHALL load the slot with no overflow.
REQ-022: Output register SHALL load when evt_valid==0, or evt_valid and evt_ready both 1 (back-to-back transfers at one per cycle).
REQ-023: Load source SHALL be a round-robin winner among full slots, search starting at (last granted channel + 1) mod NUM_INPUTS; winner's slot SHALL be cleared that cycle.
REQ-024: If no slot is full at a load opportunity, evt_valid SHALL go/stay 0.
REQ-025: While evt_valid==1 and evt_ready==0, evt_chan and evt_rising SHALL be held stable.
REQ-026: Minimum latency conditioned change -> evt_valid SHALL be 1 cycle (slot set at edge T, evt_valid at edge T+1).
REQ-027: Round-robin pointer SHALL update only on a grant; a lone requester SHALL be granted every opportunity.

Reset
REQ-028: On rst_n low, sync flops, counters, conditioned, slots, evt_valid, evt_chan, evt_rising, RR pointer (last granted = NUM_INPUTS-1) and overflow SHALL clear to 0 immediately.
REQ-029: Reset mid-transfer SHALL drop presented and pending events without completion.
REQ-030: Input held high through reset release SHALL produce one rising event after 2+WAITTIME+1+1 cycles.

Configuration
REQ-031: Macro BUTTON_EVENT_OVERFLOW_EN SHALL compile in overflow reporting.
REQ-032: With it defined, overflow[i] SHALL set on REQ-020 and stay set until overflow_clr; set and clear in same cycle SHALL leave it set.
REQ-033: Without it, overflow and overflow_clr ports SHALL be absent; overwrite behaviour SHALL be unchanged.
REQ-034: Ports in REQ-013/014 SHALL exist only when BUTTON_EVENT_OVERFLOW_EN is defined.

Structure
REQ-035: Package button_event_pkg SHALL hold CHAN_W derivation function, event record typedef {chan, rising}, and default WAITTIME/COUNTERWIDTH constants.
REQ-036: Sub-module chan_debouncer SHALL implement REQ-015..018 for one channel (outputs level and rise/fall pulses) and be instantiated NUM_INPUTS times.

Verification
REQ-037: noisy[1] 0->1 held, evt_ready=1, WAITTIME=3 -> conditioned[1] rises at cycle 6, evt_valid=1 chan=1 rising=1 at cycle 7 for one cycle.
REQ-038: noisy[0] 2-cycle high glitch -> conditioned[0] stays 0, no event.
REQ-039: noisy[0..3] rise same cycle, evt_ready=1 -> events chan 0,1,2,3 on consecutive cycles; repeat falls -> order 0,1,2,3 again.
REQ-040: evt_ready=0 for 20 cycles while channel 2 rises then falls -> single event chan=2 rising=0 presented, overflow[2]=1; overflow_clr -> 0.
REQ-041: rst_n low while evt_valid=1 -> evt_valid, conditioned, overflow 0 same cycle; no event after release with inputs low.
